// File: rtl/fft_ctrl_pkg.sv
// Shared types and widths for the FFT sampler control slice.
package fft_ctrl_pkg;
  localparam int BUCKET_W = 11;
  localparam int ADDR_W   = 10;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_FRAME,
    START,
    SWEEP,
    FILTER,
    HOLDOFF
  } state_e;
endpackage

// File: rtl/bucket_stabilizer.sv
// Debounces sampler buckets: a candidate must repeat (within TOLERANCE)
// CONFIRM_COUNT times in a row before it is published as the note.
module bucket_stabilizer
  import fft_ctrl_pkg::*;
#(
  parameter int CONFIRM_COUNT = 3,
  parameter int TOLERANCE     = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                eval,
  input  logic [BUCKET_W-1:0] bucket,
  output logic [BUCKET_W-1:0] note_bucket,
  output logic                note_valid
);
  localparam int CNT_W = $clog2(CONFIRM_COUNT + 1);

  logic [BUCKET_W-1:0] cand, cand_nx, diff;
  logic [CNT_W-1:0]    conf, conf_nx;
  logic                publish;

  always_comb begin
    diff    = (bucket >= cand) ? bucket - cand : cand - bucket;
    cand_nx = cand;
    conf_nx = conf;
    if (diff <= BUCKET_W'(TOLERANCE)) begin
      if (conf != CNT_W'(CONFIRM_COUNT)) conf_nx = conf + 1'b1;
    end else begin
      cand_nx = bucket;
      conf_nx = CNT_W'(1);
    end
    publish = eval && (conf_nx == CNT_W'(CONFIRM_COUNT)) && (cand_nx != note_bucket);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cand        <= '0;
      conf        <= '0;
      note_bucket <= '0;
      note_valid  <= 1'b0;
    end else begin
      note_valid <= publish;
      if (eval) begin
        cand <= cand_nx;
        conf <= conf_nx;
      end
      if (publish) note_bucket <= cand_nx;
    end
  end
endmodule

// File: rtl/fft_sampler_ctrl.sv
// Sequences one sampler sweep per FFT frame, arbitrates the shared BRAM read
// port between sampler and display, and feeds results to the stabilizer.
module fft_sampler_ctrl
  import fft_ctrl_pkg::*;
#(
  parameter int CONFIRM_COUNT  = 3,
  parameter int TOLERANCE      = 1,
  parameter int TIMEOUT_CYCLES = 400,
  parameter int HOLDOFF_CYCLES = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                enable,
  input  logic                frame_done,
  output logic                samp_start,
  input  logic                samp_read_enable,
  input  logic [ADDR_W-1:0]   samp_read_addr,
  input  logic                samp_done,
  input  logic [BUCKET_W-1:0] samp_bucket,
  input  logic                disp_req,
  input  logic [ADDR_W-1:0]   disp_addr,
  output logic                disp_grant,
  output logic                bram_en,
  output logic [ADDR_W-1:0]   bram_addr,
  output logic                fft_hold,
  output logic [BUCKET_W-1:0] note_bucket,
  output logic                note_valid,
  output logic                timeout_err
);
  localparam int CNT_MAX = (TIMEOUT_CYCLES > HOLDOFF_CYCLES) ? TIMEOUT_CYCLES : HOLDOFF_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  state_e              state, state_nx;
  logic [CNT_W-1:0]    cnt;
  logic [BUCKET_W-1:0] samp_latch;
  logic                timeout_hit, samp_own;

  // Counter value TIMEOUT_CYCLES-2 in the final SWEEP cycle makes the whole
  // START..SWEEP window exactly TIMEOUT_CYCLES long; a done in that cycle wins.
  always_comb begin
    state_nx    = state;
    timeout_hit = (state == SWEEP) && !samp_done && (cnt == CNT_W'(TIMEOUT_CYCLES - 2));
    case (state)
      IDLE:       if (enable) state_nx = WAIT_FRAME;
      WAIT_FRAME: if (!enable) state_nx = IDLE;
                  else if (frame_done) state_nx = START;
      START:      state_nx = SWEEP;
      SWEEP:      if (samp_done) state_nx = FILTER;
                  else if (timeout_hit) state_nx = HOLDOFF;
      FILTER:     state_nx = HOLDOFF;
      HOLDOFF:    if (cnt == CNT_W'(HOLDOFF_CYCLES - 1)) state_nx = enable ? WAIT_FRAME : IDLE;
      default:    state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      samp_latch  <= '0;
      timeout_err <= 1'b0;
    end else begin
      state <= state_nx;
      if (state != HOLDOFF && state_nx == HOLDOFF) cnt <= '0;
      else if (state == START) cnt <= '0;
      else if (state == SWEEP || state == HOLDOFF) cnt <= cnt + 1'b1;
      if (state == SWEEP && samp_done) begin
        samp_latch  <= samp_bucket;
        timeout_err <= 1'b0;
      end else if (timeout_hit) begin
        timeout_err <= 1'b1;
      end
    end
  end

  assign samp_start = (state == START);
  assign samp_own   = (state == START) || (state == SWEEP);
  assign fft_hold   = samp_own;
  assign disp_grant = samp_own ? 1'b0 : disp_req;
  assign bram_en    = samp_own ? samp_read_enable : disp_req;
  assign bram_addr  = samp_own ? samp_read_addr : disp_addr;

  bucket_stabilizer #(
    .CONFIRM_COUNT(CONFIRM_COUNT),
    .TOLERANCE    (TOLERANCE)
  ) u_stab (
    .clk        (clk),
    .rst        (rst),
    .eval       (state == FILTER),
    .bucket     (samp_latch),
    .note_bucket(note_bucket),
    .note_valid (note_valid)
  );
endmodule

// File: tb/tb_fft_sampler_ctrl.sv
// Directed + randomized bench for fft_sampler_ctrl with a behavioural note filter model.
module tb_fft_sampler_ctrl;
  localparam int CC  = 3;
  localparam int TOL = 1;
  localparam int TO  = 400;
  localparam int HO  = 16;

  logic        clk = 1'b0;
  logic        rst, enable, frame_done, samp_start;
  logic        samp_read_enable, samp_done, disp_req, disp_grant, bram_en;
  logic [9:0]  samp_read_addr, disp_addr, bram_addr;
  logic [10:0] samp_bucket, note_bucket;
  logic        fft_hold, note_valid, timeout_err;

  int checks = 0;
  int errors = 0;
  int m_cand, m_conf, m_note;

  fft_sampler_ctrl #(
    .CONFIRM_COUNT(CC), .TOLERANCE(TOL), .TIMEOUT_CYCLES(TO), .HOLDOFF_CYCLES(HO)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable), .frame_done(frame_done),
    .samp_start(samp_start), .samp_read_enable(samp_read_enable),
    .samp_read_addr(samp_read_addr), .samp_done(samp_done), .samp_bucket(samp_bucket),
    .disp_req(disp_req), .disp_addr(disp_addr), .disp_grant(disp_grant),
    .bram_en(bram_en), .bram_addr(bram_addr), .fft_hold(fft_hold),
    .note_bucket(note_bucket), .note_valid(note_valid), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic rand_ports();
    samp_read_addr   = 10'($urandom_range(0, 1023));
    samp_read_enable = 1'($urandom_range(0, 1));
    disp_addr        = 10'($urandom_range(0, 1023));
    disp_req         = ($urandom_range(0, 3) != 0);
  endtask

  // Filter rule from first principles: distance to candidate, confirm run length.
  task automatic model_eval(input int b, output bit pulse);
    int d;
    pulse = 0;
    d = (b > m_cand) ? b - m_cand : m_cand - b;
    if (d <= TOL) m_conf = (m_conf + 1 > CC) ? CC : m_conf + 1;
    else begin
      m_cand = b;
      m_conf = 1;
    end
    if (m_conf == CC && m_cand != m_note) begin
      m_note = m_cand;
      pulse  = 1;
    end
  endtask

  task automatic check_display_port(input string tag);
    check({tag, "_grant"}, 32'(disp_grant), 32'(disp_req));
    check({tag, "_en"},    32'(bram_en),    32'(disp_req));
    check({tag, "_addr"},  32'(bram_addr),  32'(disp_addr));
  endtask

  task automatic check_sampler_port(input string tag);
    check({tag, "_grant"}, 32'(disp_grant), 0);
    check({tag, "_en"},    32'(bram_en),    32'(samp_read_enable));
    check({tag, "_addr"},  32'(bram_addr),  32'(samp_read_addr));
    check({tag, "_hold"},  32'(fft_hold),   1);
  endtask

  // Entered in the first HOLDOFF cycle; leaves in the cycle after HOLDOFF.
  task automatic finish_holdoff();
    for (int j = 1; j < HO; j++) begin
      cyc();
      frame_done = (j == HO - 1) ? 1'b1 : 1'($urandom_range(0, 1));
      rand_ports();
      settle();
      check("holdoff_no_start", 32'(samp_start), 0);
      check("holdoff_valid_low", 32'(note_valid), 0);
      check_display_port("holdoff");
    end
    cyc();
    frame_done = 1'b0;
  endtask

  task automatic do_sweep(input int b, input int lat, input bit drop_en);
    bit pulse;
    frame_done = 1'b1;
    settle();
    check("wait_no_start", 32'(samp_start), 0);
    cyc();
    frame_done = 1'b0;
    rand_ports();
    settle();
    check("start_pulse", 32'(samp_start), 1);
    check_sampler_port("start");
    cyc();
    if (drop_en) enable = 1'b0;
    for (int i = 0; i < lat; i++) begin
      rand_ports();
      settle();
      check("sweep_start_low", 32'(samp_start), 0);
      check_sampler_port("sweep");
      cyc();
    end
    rand_ports();
    samp_done   = 1'b1;
    samp_bucket = 11'(b);
    settle();
    check_sampler_port("done");
    cyc();
    samp_done   = 1'b0;
    samp_bucket = 11'($urandom_range(0, 2047));
    rand_ports();
    settle();
    check("filter_hold", 32'(fft_hold), 0);
    check("filter_no_valid", 32'(note_valid), 0);
    check_display_port("filter");
    model_eval(b, pulse);
    cyc();
    settle();
    check("note_valid", 32'(note_valid), 32'(pulse));
    check("note_bucket", 32'(note_bucket), 32'(m_note));
    check("timeout_clear", 32'(timeout_err), 0);
    finish_holdoff();
    if (drop_en) begin
      frame_done = 1'b1;
      cyc();
      frame_done = 1'b0;
      settle();
      check("idle_no_start", 32'(samp_start), 0);
      check("idle_no_hold", 32'(fft_hold), 0);
      enable = 1'b1;
      cyc();
    end
  endtask

  task automatic do_timeout();
    frame_done = 1'b1;
    cyc();
    frame_done = 1'b0;
    settle();
    check("to_start_pulse", 32'(samp_start), 1);
    for (int k = 2; k <= TO; k++) begin
      cyc();
      rand_ports();
      settle();
      if (k == TO) begin
        check("to_early_err", 32'(timeout_err), 0);
        check_sampler_port("to_last");
      end
    end
    cyc();
    rand_ports();
    settle();
    check("to_err_set", 32'(timeout_err), 1);
    check("to_hold_low", 32'(fft_hold), 0);
    check("to_note_kept", 32'(note_bucket), 32'(m_note));
    check("to_no_valid", 32'(note_valid), 0);
    check_display_port("to_holdoff");
    finish_holdoff();
  endtask

  initial begin
    rst = 1'b1; enable = 1'b0; frame_done = 1'b0; samp_done = 1'b0;
    samp_bucket = '0; samp_read_enable = 1'b0; samp_read_addr = '0;
    disp_req = 1'b1; disp_addr = 10'd321;
    m_cand = 0; m_conf = 0; m_note = 0;
    repeat (3) cyc();
    settle();
    check("rst_start", 32'(samp_start), 0);
    check("rst_hold", 32'(fft_hold), 0);
    check("rst_valid", 32'(note_valid), 0);
    check("rst_note", 32'(note_bucket), 0);
    check("rst_timeout", 32'(timeout_err), 0);
    check_display_port("rst");
    rst = 1'b0;
    enable = 1'b1;
    cyc();

    // Three matching sweeps publish, a fourth does not.
    repeat (4) do_sweep(42, $urandom_range(0, 10), 1'b0);
    // Tolerance window.
    do_sweep(100, 3, 1'b0); do_sweep(101, 0, 1'b0); do_sweep(100, 5, 1'b0);
    do_sweep(42, 2, 1'b0);  do_sweep(50, 1, 1'b0);  do_sweep(42, 4, 1'b0);
    do_sweep(42, 0, 1'b0);  do_sweep(42, 2, 1'b0);
    // Extremes of the bucket range must not wrap into a match.
    repeat (3) do_sweep(2047, $urandom_range(0, 6), 1'b0);
    repeat (3) do_sweep(0, $urandom_range(0, 6), 1'b0);

    // Timeout, then a done that lands on the final permitted cycle.
    do_timeout();
    do_sweep(7, TO - 2, 1'b0);

    // Enable dropped mid-sweep: sweep completes, FSM parks in IDLE.
    do_sweep(7, 6, 1'b1);

    // Enable dropped in WAIT_FRAME: a frame on the IDLE cycle is lost.
    enable = 1'b0;
    cyc();
    enable = 1'b1;
    frame_done = 1'b1;
    cyc();
    frame_done = 1'b0;
    settle();
    check("wait_drop_no_start", 32'(samp_start), 0);

    for (int n = 0; n < 20; n++) begin
      int base;
      base = (n % 5 == 0) ? $urandom_range(0, 2047) : base;
      do_sweep((base + $urandom_range(0, 2)) % 2048, $urandom_range(0, 15), 1'b0);
    end

    // Reset in the middle of a sweep after a timeout with a published note.
    repeat (3) do_sweep(777, 1, 1'b0);
    do_timeout();
    frame_done = 1'b1;
    cyc();
    frame_done = 1'b0;
    repeat (5) cyc();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    settle();
    check("mrst_hold", 32'(fft_hold), 0);
    check("mrst_start", 32'(samp_start), 0);
    check("mrst_note", 32'(note_bucket), 0);
    check("mrst_timeout", 32'(timeout_err), 0);
    check("mrst_valid", 32'(note_valid), 0);
    m_cand = 0; m_conf = 0; m_note = 0;
    cyc();
    repeat (3) do_sweep(9, $urandom_range(0, 4), 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog expired observed running expected finished");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/fft_sampler_ctrl.md
FFT_SAMPLER_CTRL -- requirements
Module: fft_sampler_ctrl

Interface
REQ-001 Parameter CONFIRM_COUNT, default 3: consecutive matching sweeps needed before the published note changes.
REQ-002 Parameter TOLERANCE, default 1: maximum bucket difference that still counts as a match.
REQ-003 Parameter TIMEOUT_CYCLES, default 400: maximum cycles from sampler start to sampler done.
REQ-004 Parameter HOLDOFF_CYCLES, default 16: idle cycles between one sweep's end and arming for the next frame.
REQ-005 Port clk, input, 1: single clock; all logic is on its rising edge.
REQ-006 Port rst, input, 1: reset, synchronous and active-high.
REQ-007 Port enable, input, 1: level; allows the capture cycle to run.
REQ-008 Port frame_done, input, 1: one-cycle pulse; a new FFT magnitude frame is complete in BRAM.
REQ-009 Port samp_start, output, 1: one-cycle start pulse to the sampler.
REQ-010 Port samp_read_enable, input, 1: sampler's BRAM read request.
REQ-011 Port samp_read_addr, input, 10: sampler's BRAM read address.
REQ-012 Port samp_done, input, 1: sampler's one-cycle done pulse.
REQ-013 Port samp_bucket, input, 11: sampler result; 0 means silence.
REQ-014 Port disp_req, input, 1: display reader's BRAM read request.
REQ-015 Port disp_addr, input, 10: display reader's BRAM read address.
REQ-016 Port disp_grant, output, 1: display access granted this cycle.
REQ-017 Port bram_en, output, 1: muxed BRAM read enable.
REQ-018 Port bram_addr, output, 10: muxed BRAM read address.
REQ-019 Port fft_hold, output, 1: high tells the FFT writer to stall frame writes.
REQ-020 Port note_bucket, output, 11: stable published bucket.
REQ-021 Port note_valid, output, 1: one-cycle pulse when note_bucket changes.
REQ-022 Port timeout_err, output, 1: sticky flag; the last sweep timed out.

Function
REQ-023 The FSM SHALL have states IDLE, WAIT_FRAME, START, SWEEP, FILTER and HOLDOFF.
REQ-024 Transitions: IDLE->WAIT_FRAME on enable; WAIT_FRAME->START on frame_done; START->SWEEP after exactly 1 cycle; SWEEP->FILTER on samp_done; FILTER->HOLDOFF after 1 cycle.
REQ-025 HOLDOFF SHALL last HOLDOFF_CYCLES cycles, then go to WAIT_FRAME if enable is high, else IDLE.
REQ-026 samp_start SHALL be high only in START; fft_hold SHALL be high only in START and SWEEP.
REQ-027 frame_done SHALL be ignored in all states except WAIT_FRAME; missed frames are not queued.
REQ-028 Timeout counter: cleared in START, incremented each SWEEP cycle.
REQ-029 Timeout: if the counter reaches TIMEOUT_CYCLES-1 without samp_done, the FSM SHALL go to HOLDOFF, set timeout_err, and leave filter state unchanged.
REQ-030 If samp_done and the timeout coincide, samp_done SHALL win.
REQ-031 Any sweep that completes normally SHALL clear timeout_err.
REQ-032 In SWEEP, samp_bucket SHALL be latched on samp_done.
REQ-033 FILTER, match case (|latched - candidate| <= TOLERANCE): confirm count increments, saturating at CONFIRM_COUNT.
REQ-034 FILTER, mismatch case: candidate <= latched, confirm count <= 1.
REQ-035 Bucket 0 SHALL be filtered the same way as any other bucket.
REQ-036 Publish rule: when the updated confirm count equals CONFIRM_COUNT and candidate != note_bucket, note_bucket <= candidate and note_valid pulses the cycle after FILTER.
REQ-037 Otherwise note_valid SHALL stay low.
REQ-038 Bucket differences SHALL be computed unsigned over 11 bits (larger minus smaller).
REQ-039 Arbitration is combinational; in START and SWEEP the sampler owns the port: bram_en = samp_read_enable, bram_addr = samp_read_addr, disp_grant = 0.
REQ-040 In all other states the display owns the port: disp_grant = bram_en = disp_req, bram_addr = disp_addr.
REQ-041 Deasserting enable in WAIT_FRAME SHALL go to IDLE next cycle.
REQ-042 Deasserting enable in START/SWEEP SHALL not abort the sweep; FILTER still runs, and HOLDOFF then exits to IDLE.

Reset
REQ-043 On rst: state IDLE, all counters 0, candidate 0, confirm count 0, note_bucket 0, and every output 0 except the combinational display mux.
REQ-044 rst SHALL override every state, including mid-SWEEP.

Structure
REQ-045 Package fft_ctrl_pkg SHALL hold the state enum, BUCKET_W = 11 and ADDR_W = 10.
REQ-046 The filter (REQ-033..038) SHALL be sub-module bucket_stabilizer, taking one evaluate pulse plus bucket and returning note_bucket and note_valid.

Verification
REQ-047 Published note: three sweeps returning 42 -> one note_valid, note_bucket = 42, pulse the cycle after the third FILTER; a fourth 42 gives no pulse.
REQ-048 Tolerance: sequence 42, 43, 42 -> publishes 42; sequence 42, 50, 42 -> no publish, confirm count = 1.
REQ-049 Timeout: samp_done withheld -> timeout_err = 1 exactly 400 cycles after samp_start, FSM in HOLDOFF, note unchanged; next good sweep clears timeout_err.
REQ-050 Arbitration: disp_req held high -> disp_grant = 0 from START through the last SWEEP cycle, bram_addr tracks samp_read_addr; grant returns in the FILTER cycle.
REQ-051 Enable/frame handling: enable dropped mid-SWEEP -> sweep completes, FILTER runs, FSM ends in IDLE; frame_done in IDLE or HOLDOFF -> no samp_start.
REQ-052 Reset mid-SWEEP: rst pulse -> next cycle fft_hold = 0, samp_start = 0, note_bucket = 0, timeout_err = 0, state IDLE.
